// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter for the dm_4k word memory, with read-modify-write byte stores.
// Define DM_ARB_M0_PRIO_EN to give M0 fixed priority instead of round-robin.
module dm_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_be,
    output logic                  m0_ack,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W/8-1:0]   m1_be,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [ADDR_W-1:0]     dm_addr,
    output logic [DATA_W-1:0]     dm_din,
    output logic                  dm_we,
    input  logic [DATA_W-1:0]     dm_dout,
    output logic                  busy
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic {ST_IDLE, ST_RMW} state_t;

    state_t              state_q;
    logic                m0_ack_q, m1_ack_q;
    logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
    logic [ADDR_W-1:0]   rmw_addr_q;
    logic [DATA_W-1:0]   rmw_data_q, rmw_data_d;
    logic                rmw_owner_q;
`ifndef DM_ARB_M0_PRIO_EN
    logic                last_grant_q;
`endif

    logic                elig0, elig1, grant, win;
    logic                w_we, be_full, be_zero;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [BE_W-1:0]     w_be;

    always_comb begin
        // A master whose ack is on the wire this cycle still shows its old request.
        elig0 = m0_req & ~m0_ack_q;
        elig1 = m1_req & ~m1_ack_q;
`ifdef DM_ARB_M0_PRIO_EN
        win = ~elig0;
`else
        win = (elig0 & elig1) ? ~last_grant_q : elig1;
`endif
        grant   = (state_q == ST_IDLE) & (elig0 | elig1);
        w_we    = win ? m1_we    : m0_we;
        w_addr  = win ? m1_addr  : m0_addr;
        w_wdata = win ? m1_wdata : m0_wdata;
        w_be    = win ? m1_be    : m0_be;
        be_full = &w_be;
        be_zero = ~|w_be;

        rmw_data_d = dm_dout;
        for (int i = 0; i < BE_W; i++) begin
            if (w_be[i]) rmw_data_d[i*8 +: 8] = w_wdata[i*8 +: 8];
        end

        dm_addr = '0;
        dm_din  = '0;
        dm_we   = 1'b0;
        if (state_q == ST_RMW) begin
            dm_addr = rmw_addr_q;
            dm_din  = rmw_data_q;
            dm_we   = ~rst;
        end else if (grant) begin
            dm_addr = w_addr;
            dm_din  = w_wdata;
            dm_we   = w_we & be_full & ~rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifndef DM_ARB_M0_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
`ifndef DM_ARB_M0_PRIO_EN
                        last_grant_q <= win;
`endif
                        if (!w_we || be_full || be_zero) begin
                            if (win) m1_ack_q <= 1'b1;
                            else     m0_ack_q <= 1'b1;
                            if (!w_we) begin
                                if (win) m1_rdata_q <= dm_dout;
                                else     m0_rdata_q <= dm_dout;
                            end
                        end else begin
                            // Partial store: merge now, write the whole word next cycle.
                            rmw_addr_q  <= w_addr;
                            rmw_owner_q <= win;
                            rmw_data_q  <= rmw_data_d;
                            state_q     <= ST_RMW;
                        end
                    end
                end
                ST_RMW: begin
                    if (rmw_owner_q) m1_ack_q <= 1'b1;
                    else             m0_ack_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign busy     = (state_q == ST_RMW);

endmodule
